// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial UART transmitter, one bit per clk cycle.
//
// The clock is already divided down to the baud rate, so each FSM state that
// drives the line lasts exactly one clk cycle (DATA lasts DATA_WIDTH cycles).
// Frame on TX_OUT: start bit (0), DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit (1). The line idles high.
//
// Compile-time option:
//   UART_TX_PARITY_EN  defined   -> PARITY state and parity logic are built;
//                                   PAR_EN / PAR_TYP select parity per frame.
//                      undefined -> no parity hardware; PAR_EN / PAR_TYP are
//                                   accepted as ports but ignored, and every
//                                   frame is DATA_WIDTH+2 cycles.
//
// Parameters:
//   DATA_WIDTH  number of data bits per frame (default 8)
//
// Ports:
//   clk         TX bit clock
//   rst         asynchronous, active-low reset
//   P_DATA      parallel word to transmit
//   DATA_VALID  one-cycle transmit request, honoured only while idle
//   PAR_EN      1 appends a parity bit to the frame
//   PAR_TYP     0 = even parity, 1 = odd parity
//   TX_OUT      registered serial line output
//   busy        registered, high while a frame is on the line
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    // Bit counter wide enough to index every data bit (at least 1 bit wide).
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [CNT_W-1:0]        bit_cnt_nxt_s;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   data_nxt_s;
    // tx_nxt_s / busy_nxt_s are the line values for the state being entered,
    // so the registered outputs line up with the state register.
    logic                    tx_r;
    logic                    tx_nxt_s;
    logic                    busy_r;
    logic                    busy_nxt_s;

`ifdef UART_TX_PARITY_EN
    logic                    par_en_r;
    logic                    par_en_nxt_s;
    logic                    par_typ_r;
    logic                    par_typ_nxt_s;

    // Even parity is the XOR-reduction of the word; odd parity inverts it.
    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] word,
                                      input logic                  odd);
        return (^word) ^ odd;
    endfunction
`else
    // Parity controls have no function in this build.
    logic                    unused_par_s;
    assign unused_par_s = PAR_EN ^ PAR_TYP;
`endif

    // Next-state, next-line-value and capture logic for the transmit FSM.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        data_nxt_s    = data_r;
        tx_nxt_s      = 1'b1;
        busy_nxt_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_nxt_s  = par_en_r;
        par_typ_nxt_s = par_typ_r;
`endif

        case (state_r)
            IDLE: begin
                if (DATA_VALID) begin
                    // Everything the frame needs is captured here, so later
                    // changes on the inputs cannot disturb the frame in flight.
                    state_nxt_s   = START;
                    data_nxt_s    = P_DATA;
                    bit_cnt_nxt_s = CNT_ZERO;
`ifdef UART_TX_PARITY_EN
                    par_en_nxt_s  = PAR_EN;
                    par_typ_nxt_s = PAR_TYP;
`endif
                    tx_nxt_s      = 1'b0;
                    busy_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s   = IDLE;
                    tx_nxt_s      = 1'b1;
                    busy_nxt_s    = 1'b0;
                end
            end

            START: begin
                state_nxt_s   = DATA;
                bit_cnt_nxt_s = CNT_ZERO;
                tx_nxt_s      = data_r[0];
                busy_nxt_s    = 1'b1;
            end

            DATA: begin
                busy_nxt_s = 1'b1;
                if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    if (par_en_r) begin
                        state_nxt_s = PARITY;
                        tx_nxt_s    = parity_f(data_r, par_typ_r);
                    end else begin
                        state_nxt_s = STOP;
                        tx_nxt_s    = 1'b1;
                    end
`else
                    state_nxt_s = STOP;
                    tx_nxt_s    = 1'b1;
`endif
                end else begin
                    state_nxt_s   = DATA;
                    bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                    tx_nxt_s      = data_r[bit_cnt_nxt_s];
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_nxt_s = STOP;
                tx_nxt_s    = 1'b1;
                busy_nxt_s  = 1'b1;
            end
`endif

            STOP: begin
                // Leaving STOP always passes through IDLE, which guarantees
                // at least one idle cycle between frames.
                state_nxt_s = IDLE;
                tx_nxt_s    = 1'b1;
                busy_nxt_s  = 1'b0;
            end

            default: begin
                state_nxt_s   = IDLE;
                bit_cnt_nxt_s = CNT_ZERO;
                tx_nxt_s      = 1'b1;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, counter, data and output registers; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= CNT_ZERO;
            data_r    <= {DATA_WIDTH{1'b0}};
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            data_r    <= data_nxt_s;
            tx_r      <= tx_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Per-frame parity settings captured at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else begin
            par_en_r  <= par_en_nxt_s;
            par_typ_r <= par_typ_nxt_s;
        end
    end
`endif

    assign TX_OUT = tx_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx (DATA_WIDTH = 8).
// Works with UART_TX_PARITY_EN either defined or undefined.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         TX_OUT;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       exp_par;     // hand-computed parity bit
        int         inject_cycle; // frame cycle in which a 0xFF request is raised, -1 none
        bit         inject_stop;  // raise the 0xFF request during the stop bit
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            check($sformatf("%s idle busy c%0d", tag, c), busy, 1'b0);
            check($sformatf("%s idle tx c%0d", tag, c), TX_OUT, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns at the first idle sample.
    task automatic run_frame(input vec_t v);
        logic        par_on;
        int          len;
        logic [15:0] seq;
        par_on = PAR_BUILT & v.par_en;
        len    = W + 2 + (par_on ? 1 : 0);
        seq    = 16'h0000;
        for (int b = 0; b < W; b++) seq[1 + b] = v.data[b];
        if (par_on) seq[W + 1] = v.exp_par;
        seq[len - 1] = 1'b1;

        P_DATA = v.data; PAR_EN = v.par_en; PAR_TYP = v.par_typ; DATA_VALID = 1'b1;
        @(posedge clk); #1;
        DATA_VALID = 1'b0;
        P_DATA = ~v.data; PAR_EN = ~v.par_en; PAR_TYP = ~v.par_typ;
        for (int i = 0; i < len; i++) begin
            check($sformatf("d%02h tx[%0d]", v.data, i), TX_OUT, seq[i]);
            check($sformatf("d%02h busy[%0d]", v.data, i), busy, 1'b1);
            if (i == v.inject_cycle || (v.inject_stop && i == len - 1)) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'hFF;
            end
            @(posedge clk); #1;
            DATA_VALID = 1'b0;
        end
        check($sformatf("d%02h end busy", v.data), busy, 1'b0);
        check($sformatf("d%02h end tx", v.data), TX_OUT, 1'b1);
    endtask

    initial begin
        //               data   pe    pt    par   inj  stop
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, -1, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1, -1, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 1'b0, -1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, -1, 1'b0};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0,  3, 1'b0};
        vecs[7] = '{8'h3C, 1'b1, 1'b1, 1'b1, -1, 1'b1};

        rst = 1'b0; P_DATA = 8'h00; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #12;
        check("reset tx", TX_OUT, 1'b1);
        check("reset busy", busy, 1'b0);

        // Release just after an edge; the very next edge must accept vecs[0].
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k]);
            if (vecs[k].inject_cycle >= 0 || vecs[k].inject_stop)
                check_idle(3, $sformatf("drop%0d", k));
        end

        // Reset during data bit 3 of 0x3C.
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(posedge clk); #1;
        DATA_VALID = 1'b0;
        check("rst3c start", TX_OUT, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            check($sformatf("rst3c bit%0d", b), TX_OUT, (8'h3C >> b) & 8'h01);
        end
        check("rst3c busy before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("rst3c tx async", TX_OUT, 1'b1);
        check("rst3c busy async", busy, 1'b0);
        @(posedge clk); #1;
        check("rst3c held busy", busy, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle(2, "post-rst");
        run_frame('{8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b0});
        run_frame('{8'h55, 1'b1, 1'b0, 1'b0, -1, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, which sets the number of data bits per frame.
REQ-002 SHALL have port clk, input, 1 bit: the TX clock; one serial bit is sent per clk cycle, and clk is pre-divided to the baud rate.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH bits: the parallel byte to transmit.
REQ-005 SHALL have port DATA_VALID, input, 1 bit: a one-cycle request to transmit P_DATA.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 appends a parity bit to the frame.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 SHALL have port TX_OUT, output, 1 bit: the serial line; it idles high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is on the line.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, SHALL accept a request when DATA_VALID=1, registering P_DATA, PAR_EN and PAR_TYP and moving to START on the next edge.
REQ-012 SHALL ignore DATA_VALID in every state except IDLE; a request made while busy is dropped, not queued.
REQ-013 Frame timing: START drives TX_OUT=0 for 1 cycle, starting in the cycle after acceptance.
REQ-014 DATA SHALL drive the latched data LSB first for DATA_WIDTH cycles, using a bit counter from 0 to DATA_WIDTH-1.
REQ-015 After DATA, the FSM SHALL go to PARITY if the latched PAR_EN=1; otherwise it SHALL go to STOP.
REQ-016 PARITY SHALL drive, for 1 cycle, the XOR-reduction of the latched data, inverted when the latched PAR_TYP=1.
REQ-017 STOP SHALL drive TX_OUT=1 for 1 cycle and then return to IDLE.
REQ-018 TX_OUT SHALL be registered, with no combinational path from any input to TX_OUT.
REQ-019 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-020 Frame length SHALL be DATA_WIDTH+2 cycles, or DATA_WIDTH+3 cycles with parity.
REQ-021 There SHALL be at least one IDLE cycle between consecutive frames.
REQ-022 Changes to P_DATA, PAR_EN or PAR_TYP after acceptance SHALL NOT affect the frame in flight.
REQ-023 Parity SHALL be computed from the latched data only.

Reset
REQ-024 On rst=0, SHALL asynchronously force state=IDLE, TX_OUT=1, busy=0, and clear the bit counter and data register.
REQ-025 A reset asserted mid-frame SHALL abort the frame immediately, with no partial stop bit; after release, the block SHALL wait in IDLE for a new DATA_VALID.
REQ-026 SHALL accept DATA_VALID on the first clk edge after rst deasserts.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: the PARITY state and parity logic SHALL be built, and PAR_EN and PAR_TYP SHALL behave as specified above.
REQ-028 UART_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be omitted, PAR_EN and PAR_TYP SHALL remain as ports but be ignored, and every frame SHALL be DATA_WIDTH+2 cycles.

Verification
REQ-029 P_DATA=0xA5, PAR_EN=0, DATA_VALID pulse: TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; busy high for exactly 10 cycles; TX_OUT=1 afterwards.
REQ-030 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 (macro defined): parity bit 0 sent after the data bits; frame is 11 cycles.
REQ-031 P_DATA=0x01, PAR_EN=1: PAR_TYP=0 gives parity bit 1; PAR_TYP=1 gives parity bit 0.
REQ-032 Second DATA_VALID pulse (P_DATA=0xFF) in the 4th cycle of a 0x00 frame: frame 0x00 completes unchanged and 0xFF is never sent.
REQ-033 rst asserted during data bit 3 of 0x3C: TX_OUT=1 and busy=0 immediately; a new 0x55 request after release transmits a full, correct frame.
REQ-034 Macro undefined, PAR_EN=1, P_DATA=0x81: frame is 10 cycles with no parity bit.
